// File: rtl/ipu_arb_merge_slicer.sv
// ============================================================================
// ipu_arb_merge_slicer
// ----------------------------------------------------------------------------
// Purpose:
//   Merges NUM_IN flit sources onto a single path. The source is chosen either
//   by an internal round-robin arbiter (EXT_SEL=0) or by tokens arriving on an
//   external select channel (EXT_SEL=1). Each issued flit is split into an
//   address field (flit MSBs) and a data field (flit LSBs). The two fields
//   leave on two independently handshaked output channels. A new flit is only
//   issued when both output slots can take it, so a flit is never split across
//   cycles.
//
// Handshake rule (all channels):
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   A producer holds valid and its payload stable until the transfer. in_ready
//   and ctl_ready are combinational from the valids and internal state. Neither
//   waits for a valid that is raised only in response to it.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   [NUM_IN]       per-source flit valid
//   in_data    in   [NUM_IN*W]     flat flits, source i at [i*W +: W]
//   in_ready   out  [NUM_IN]       per-source accept, one-hot or zero
//   ctl_valid  in                  select token valid (EXT_SEL=1 only)
//   ctl_sel    in   [SEL_W]        source index to take next
//   ctl_ready  out                 select token consumed
//   addr_valid out                 address field valid
//   addr_out   out  [ADDR_W]       flit[W-1:DATA_W]
//   addr_ready in                  address consumer accept
//   data_valid out                 data field valid
//   data_out   out  [DATA_W]       flit[DATA_W-1:0]
//   data_ready in                  data consumer accept
//   err_sel    out                 one-cycle pulse: out-of-range token consumed
//   flit_cnt   out  [CNT_W]        issued flit count (wraps)
//   dbg_state  out                 select FSM state (0 = IDLE, 1 = WAIT)
// ============================================================================
module ipu_arb_merge_slicer #(
    parameter int NUM_IN  = 3,
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 4,
    parameter int SEL_W   = 2,
    parameter int EXT_SEL = 0,
    parameter int CNT_W   = 16
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_IN-1:0]                    in_valid,
    input  logic [NUM_IN*(ADDR_W+DATA_W)-1:0]    in_data,
    output logic [NUM_IN-1:0]                    in_ready,
    input  logic                                 ctl_valid,
    input  logic [SEL_W-1:0]                     ctl_sel,
    output logic                                 ctl_ready,
    output logic                                 addr_valid,
    output logic [ADDR_W-1:0]                    addr_out,
    input  logic                                 addr_ready,
    output logic                                 data_valid,
    output logic [DATA_W-1:0]                    data_out,
    input  logic                                 data_ready,
    output logic                                 err_sel,
    output logic [CNT_W-1:0]                     flit_cnt,
    output logic                                 dbg_state
);

    localparam int W     = ADDR_W + DATA_W;
    localparam int PTR_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    localparam logic [SEL_W:0]   LP_NUM_SEL = (SEL_W + 1)'(NUM_IN);
    localparam logic [PTR_W:0]   LP_NUM_PTR = (PTR_W + 1)'(NUM_IN);
    localparam logic [PTR_W-1:0] LP_LAST    = PTR_W'(NUM_IN - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             r_state;
    state_t             w_state_nxt;
    logic [SEL_W-1:0]   r_sel;
    logic [PTR_W-1:0]   r_ptr;
    logic               r_addr_valid;
    logic               r_data_valid;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_data;
    logic               r_err_sel;
    logic [CNT_W-1:0]   r_cnt;

    // ------------------------------------------------------------------
    // Combinational nets
    // ------------------------------------------------------------------
    logic               w_slot_free_a;
    logic               w_slot_free_d;
    logic               w_issue_ok;
    logic               w_issue;
    logic               w_gnt_vld;
    logic [PTR_W-1:0]   w_gnt_idx;
    logic [2*NUM_IN-1:0] w_req_rot;
    logic [PTR_W:0]     w_rr_off;
    logic [PTR_W:0]     w_rr_sum;
    logic               w_rr_found;
    logic [W-1:0]       w_flit;
    logic               w_sel_in_range;
    logic               w_sel_load;
    logic               w_err_nxt;
    logic               w_ctl_ready;

    // A slot can take a new field if it is empty or is being drained this edge.
    // Issuing needs both slots (join), which keeps the two fields of one flit
    // together.
    assign w_slot_free_a = ~r_addr_valid | addr_ready;
    assign w_slot_free_d = ~r_data_valid | data_ready;
    assign w_issue_ok    = w_slot_free_a & w_slot_free_d;
    assign w_issue       = w_gnt_vld & w_issue_ok;

    assign w_sel_in_range = ({1'b0, ctl_sel} < LP_NUM_SEL);

    // ------------------------------------------------------------------
    // Grant selection
    // ------------------------------------------------------------------
    always_comb begin
        w_gnt_vld  = 1'b0;
        w_gnt_idx  = '0;
        w_req_rot  = '0;
        w_rr_off   = '0;
        w_rr_sum   = '0;
        w_rr_found = 1'b0;

        if (EXT_SEL != 0) begin
            // Only the latched source may be granted; the others stall.
            if (r_state == ST_WAIT) begin
                for (int i = 0; i < NUM_IN; i++) begin
                    if ((r_sel == SEL_W'(i)) && in_valid[i]) begin
                        w_gnt_vld = 1'b1;
                        w_gnt_idx = PTR_W'(i);
                    end
                end
            end
        end else begin
            // Rotate the request vector so that bit 0 is the source at r_ptr,
            // take the first set bit, then rotate the offset back.
            w_req_rot = {in_valid, in_valid} >> r_ptr;
            for (int j = 0; j < NUM_IN; j++) begin
                if (!w_rr_found && w_req_rot[j]) begin
                    w_rr_found = 1'b1;
                    w_rr_off   = (PTR_W + 1)'(j);
                end
            end
            w_rr_sum = {1'b0, r_ptr} + w_rr_off;
            if (w_rr_sum >= LP_NUM_PTR) begin
                w_rr_sum = w_rr_sum - LP_NUM_PTR;
            end
            w_gnt_vld = w_rr_found;
            w_gnt_idx = w_rr_sum[PTR_W-1:0];
        end
    end

    // Flit mux for the granted source.
    always_comb begin
        w_flit = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (w_gnt_idx == PTR_W'(i)) begin
                w_flit = in_data[i*W +: W];
            end
        end
    end

    // in_ready is held low during reset so no source sees a phantom accept.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            in_ready[i] = rst_n & w_issue & (w_gnt_idx == PTR_W'(i));
        end
    end

    // ------------------------------------------------------------------
    // Select FSM (only active when EXT_SEL=1; parks in IDLE otherwise)
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_ctl_ready = 1'b0;
        w_sel_load  = 1'b0;
        w_err_nxt   = 1'b0;

        if (EXT_SEL != 0) begin
            case (r_state)
                ST_IDLE: begin
                    // IDLE always takes a token; an out-of-range one is
                    // dropped and reported instead of stalling the channel.
                    w_ctl_ready = 1'b1;
                    if (ctl_valid) begin
                        if (w_sel_in_range) begin
                            w_sel_load  = 1'b1;
                            w_state_nxt = ST_WAIT;
                        end else begin
                            w_err_nxt = 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (w_issue) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign ctl_ready = rst_n & w_ctl_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_sel     <= '0;
            r_err_sel <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_err_sel <= w_err_nxt;
            if (w_sel_load) begin
                r_sel <= ctl_sel;
            end
        end
    end

    // ------------------------------------------------------------------
    // Round-robin pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if ((EXT_SEL == 0) && w_issue) begin
            r_ptr <= (w_gnt_idx == LP_LAST) ? '0 : (w_gnt_idx + 1'b1);
        end
    end

    // ------------------------------------------------------------------
    // Output slots and flit counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr_valid <= 1'b0;
            r_data_valid <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
            r_cnt        <= '0;
        end else if (w_issue) begin
            r_addr_valid <= 1'b1;
            r_data_valid <= 1'b1;
            r_addr       <= w_flit[W-1:DATA_W];
            r_data       <= w_flit[DATA_W-1:0];
            r_cnt        <= r_cnt + 1'b1;
        end else begin
            // Without a new issue each field drains on its own handshake;
            // the sibling keeps its value until it is taken too.
            if (r_addr_valid && addr_ready) begin
                r_addr_valid <= 1'b0;
            end
            if (r_data_valid && data_ready) begin
                r_data_valid <= 1'b0;
            end
        end
    end

    assign addr_valid = r_addr_valid;
    assign addr_out   = r_addr;
    assign data_valid = r_data_valid;
    assign data_out   = r_data;
    assign err_sel    = r_err_sel;
    assign flit_cnt   = r_cnt;
    assign dbg_state  = (r_state == ST_WAIT);

endmodule

// File: tb/tb_ipu_arb_merge_slicer.sv
// ============================================================================
// tb_ipu_arb_merge_slicer
// ----------------------------------------------------------------------------
// Two instances: u_rr (defaults, round-robin) and u_ex (external select,
// 4-bit flit counter). One task per scenario, each with inline comparisons.
// ============================================================================
module tb_ipu_arb_merge_slicer;

    localparam int W = 11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- round-robin instance ----------------
    logic           rr_rst_n;
    logic [2:0]     rr_in_valid;
    logic [3*W-1:0] rr_in_data;
    logic [2:0]     rr_in_ready;
    logic           rr_ctl_valid;
    logic [1:0]     rr_ctl_sel;
    logic           rr_ctl_ready;
    logic           rr_addr_valid;
    logic [6:0]     rr_addr_out;
    logic           rr_addr_ready;
    logic           rr_data_valid;
    logic [3:0]     rr_data_out;
    logic           rr_data_ready;
    logic           rr_err_sel;
    logic [15:0]    rr_flit_cnt;
    logic           rr_dbg_state;

    ipu_arb_merge_slicer u_rr (
        .clk        (clk),
        .rst_n      (rr_rst_n),
        .in_valid   (rr_in_valid),
        .in_data    (rr_in_data),
        .in_ready   (rr_in_ready),
        .ctl_valid  (rr_ctl_valid),
        .ctl_sel    (rr_ctl_sel),
        .ctl_ready  (rr_ctl_ready),
        .addr_valid (rr_addr_valid),
        .addr_out   (rr_addr_out),
        .addr_ready (rr_addr_ready),
        .data_valid (rr_data_valid),
        .data_out   (rr_data_out),
        .data_ready (rr_data_ready),
        .err_sel    (rr_err_sel),
        .flit_cnt   (rr_flit_cnt),
        .dbg_state  (rr_dbg_state)
    );

    // ---------------- external-select instance ----------------
    logic           ex_rst_n;
    logic [2:0]     ex_in_valid;
    logic [3*W-1:0] ex_in_data;
    logic [2:0]     ex_in_ready;
    logic           ex_ctl_valid;
    logic [1:0]     ex_ctl_sel;
    logic           ex_ctl_ready;
    logic           ex_addr_valid;
    logic [6:0]     ex_addr_out;
    logic           ex_addr_ready;
    logic           ex_data_valid;
    logic [3:0]     ex_data_out;
    logic           ex_data_ready;
    logic           ex_err_sel;
    logic [3:0]     ex_flit_cnt;
    logic           ex_dbg_state;

    ipu_arb_merge_slicer #(.EXT_SEL(1), .CNT_W(4)) u_ex (
        .clk        (clk),
        .rst_n      (ex_rst_n),
        .in_valid   (ex_in_valid),
        .in_data    (ex_in_data),
        .in_ready   (ex_in_ready),
        .ctl_valid  (ex_ctl_valid),
        .ctl_sel    (ex_ctl_sel),
        .ctl_ready  (ex_ctl_ready),
        .addr_valid (ex_addr_valid),
        .addr_out   (ex_addr_out),
        .addr_ready (ex_addr_ready),
        .data_valid (ex_data_valid),
        .data_out   (ex_data_out),
        .data_ready (ex_data_ready),
        .err_sel    (ex_err_sel),
        .flit_cnt   (ex_flit_cnt),
        .dbg_state  (ex_dbg_state)
    );

    // Fixed per-source flits for directed tests.
    logic [W-1:0] fl[3];
    logic [W-1:0] ef[3];

    // ------------------------------------------------------------------
    task automatic test_reset();
        rr_rst_n = 1'b0;
        ex_rst_n = 1'b0;
        rr_in_valid = 3'b111;
        ex_in_valid = 3'b111;
        ex_ctl_valid = 1'b1;
        ex_ctl_sel = 2'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (rr_addr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_addr_valid got=%0b exp=0", rr_addr_valid); end
        n_checks++; if (rr_data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_data_valid got=%0b exp=0", rr_data_valid); end
        n_checks++; if (rr_addr_out !== 7'h0) begin n_fail++; $display("FAIL reset_addr_out got=%h exp=0", rr_addr_out); end
        n_checks++; if (rr_data_out !== 4'h0) begin n_fail++; $display("FAIL reset_data_out got=%h exp=0", rr_data_out); end
        n_checks++; if (rr_flit_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_flit_cnt got=%0d exp=0", rr_flit_cnt); end
        n_checks++; if (rr_in_ready !== 3'b000) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=000", rr_in_ready); end
        n_checks++; if (ex_in_ready !== 3'b000) begin n_fail++; $display("FAIL reset_ex_in_ready got=%b exp=000", ex_in_ready); end
        n_checks++; if (ex_ctl_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ctl_ready got=%0b exp=0", ex_ctl_ready); end
        n_checks++; if (ex_err_sel !== 1'b0) begin n_fail++; $display("FAIL reset_err_sel got=%0b exp=0", ex_err_sel); end
        n_checks++; if (ex_flit_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_ex_flit_cnt got=%0d exp=0", ex_flit_cnt); end
        @(posedge clk); #1;
        rr_in_valid = 3'b000;
        ex_in_valid = 3'b000;
        ex_ctl_valid = 1'b0;
        rr_rst_n = 1'b1;
        ex_rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (ex_ctl_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ctl_ready got=%0b exp=1", ex_ctl_ready); end
        n_checks++; if (rr_ctl_ready !== 1'b0) begin n_fail++; $display("FAIL rr_ctl_ready got=%0b exp=0", rr_ctl_ready); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_rr_fairness();
        @(posedge clk); #1;
        rr_addr_ready = 1'b1;
        rr_data_ready = 1'b1;
        rr_in_data = {fl[2], fl[1], fl[0]};
        rr_in_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_checks++; if (rr_in_ready !== 3'(1 << (k % 3))) begin n_fail++; $display("FAIL rr_grant k=%0d got=%b exp=%b", k, rr_in_ready, 3'(1 << (k % 3))); end
            if (k > 0) begin
                n_checks++; if (rr_addr_valid !== 1'b1 || rr_addr_out !== fl[(k-1)%3][10:4] || rr_data_out !== fl[(k-1)%3][3:0]) begin
                    n_fail++; $display("FAIL rr_stream k=%0d got=%0b/%h/%h exp=1/%h/%h", k, rr_addr_valid, rr_addr_out, rr_data_out, fl[(k-1)%3][10:4], fl[(k-1)%3][3:0]);
                end
            end
            @(posedge clk); #1;
        end
        rr_in_valid = 3'b000;
        @(negedge clk);
        n_checks++; if (rr_addr_out !== fl[2][10:4] || rr_data_out !== fl[2][3:0]) begin n_fail++; $display("FAIL rr_last got=%h/%h exp=%h/%h", rr_addr_out, rr_data_out, fl[2][10:4], fl[2][3:0]); end
        n_checks++; if (rr_flit_cnt !== 16'd6) begin n_fail++; $display("FAIL rr_cnt6 got=%0d exp=6", rr_flit_cnt); end
        n_checks++; if (rr_in_ready !== 3'b000) begin n_fail++; $display("FAIL rr_idle_ready got=%b exp=000", rr_in_ready); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_field_split();
        @(posedge clk); #1;
        rr_in_data = {11'h0, 11'h5A3, 11'h0};
        rr_in_valid = 3'b010;
        @(negedge clk);
        n_checks++; if (rr_in_ready !== 3'b010) begin n_fail++; $display("FAIL split_ready got=%b exp=010", rr_in_ready); end
        n_checks++; if (rr_addr_valid !== 1'b0) begin n_fail++; $display("FAIL split_pre_valid got=%0b exp=0", rr_addr_valid); end
        @(posedge clk); #1;
        rr_in_valid = 3'b000;
        @(negedge clk);
        n_checks++; if (rr_addr_valid !== 1'b1 || rr_data_valid !== 1'b1) begin n_fail++; $display("FAIL split_valids got=%0b%0b exp=11", rr_addr_valid, rr_data_valid); end
        n_checks++; if (rr_addr_out !== 7'h5A) begin n_fail++; $display("FAIL split_addr got=%h exp=5a", rr_addr_out); end
        n_checks++; if (rr_data_out !== 4'h3) begin n_fail++; $display("FAIL split_data got=%h exp=3", rr_data_out); end
        n_checks++; if (rr_flit_cnt !== 16'd7) begin n_fail++; $display("FAIL split_cnt got=%0d exp=7", rr_flit_cnt); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_join_backpressure();
        logic [W-1:0] f0;
        logic [W-1:0] f1;
        f0 = 11'h1C7;
        f1 = 11'h2B9;
        @(posedge clk); #1;
        rr_in_data = {11'h0, 11'h0, f0};
        rr_in_valid = 3'b001;
        rr_addr_ready = 1'b1;
        rr_data_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (rr_in_ready !== 3'b001) begin n_fail++; $display("FAIL join_first got=%b exp=001", rr_in_ready); end
        @(posedge clk); #1;
        rr_in_data = {11'h0, 11'h0, f1};
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_checks++; if (rr_data_valid !== 1'b1 || rr_data_out !== f0[3:0]) begin n_fail++; $display("FAIL join_data_hold c=%0d got=%0b/%h exp=1/%h", c, rr_data_valid, rr_data_out, f0[3:0]); end
            n_checks++; if (rr_addr_valid !== (c == 0)) begin n_fail++; $display("FAIL join_addr_valid c=%0d got=%0b exp=%0b", c, rr_addr_valid, (c == 0)); end
            n_checks++; if (rr_in_ready !== 3'b000) begin n_fail++; $display("FAIL join_stall c=%0d got=%b exp=000", c, rr_in_ready); end
            @(posedge clk); #1;
        end
        rr_data_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (rr_in_ready !== 3'b001) begin n_fail++; $display("FAIL join_resume got=%b exp=001", rr_in_ready); end
        @(posedge clk); #1;
        rr_in_valid = 3'b000;
        @(negedge clk);
        n_checks++; if (rr_addr_valid !== 1'b1 || rr_addr_out !== f1[10:4] || rr_data_out !== f1[3:0]) begin
            n_fail++; $display("FAIL join_next got=%0b/%h/%h exp=1/%h/%h", rr_addr_valid, rr_addr_out, rr_data_out, f1[10:4], f1[3:0]);
        end
        n_checks++; if (rr_flit_cnt !== 16'd9) begin n_fail++; $display("FAIL join_cnt got=%0d exp=9", rr_flit_cnt); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid_stream();
        logic [W-1:0] f;
        f = 11'h4E6;
        @(posedge clk); #1;
        rr_in_data = {fl[2], fl[1], fl[0]};
        rr_in_valid = 3'b111;
        rr_addr_ready = 1'b1;
        rr_data_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rr_rst_n = 1'b0;
        #1;
        n_checks++; if (rr_addr_valid !== 1'b0 || rr_data_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valids got=%0b%0b exp=00", rr_addr_valid, rr_data_valid); end
        n_checks++; if (rr_flit_cnt !== 16'd0) begin n_fail++; $display("FAIL midrst_cnt got=%0d exp=0", rr_flit_cnt); end
        n_checks++; if (rr_in_ready !== 3'b000) begin n_fail++; $display("FAIL midrst_ready got=%b exp=000", rr_in_ready); end
        rr_in_valid = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        rr_rst_n = 1'b1;
        @(posedge clk); #1;
        rr_in_data = {f, 11'h0, 11'h0};
        rr_in_valid = 3'b100;
        @(negedge clk);
        n_checks++; if (rr_addr_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_no_partial got=%0b exp=0", rr_addr_valid); end
        n_checks++; if (rr_in_ready !== 3'b100) begin n_fail++; $display("FAIL midrst_grant got=%b exp=100", rr_in_ready); end
        @(posedge clk); #1;
        rr_in_valid = 3'b000;
        @(negedge clk);
        n_checks++; if (rr_addr_valid !== 1'b1 || rr_addr_out !== f[10:4] || rr_data_out !== f[3:0]) begin
            n_fail++; $display("FAIL midrst_first got=%0b/%h/%h exp=1/%h/%h", rr_addr_valid, rr_addr_out, rr_data_out, f[10:4], f[3:0]);
        end
        n_checks++; if (rr_flit_cnt !== 16'd1) begin n_fail++; $display("FAIL midrst_cnt1 got=%0d exp=1", rr_flit_cnt); end
    endtask

    // ------------------------------------------------------------------
    // Random traffic against a transaction-level model: per-source pending
    // flits, a round-robin start index, and one expected queue per output.
    task automatic test_random_rr();
        logic [6:0]   exp_aq[$];
        logic [3:0]   exp_dq[$];
        logic         sv[3];
        logic [W-1:0] sd[3];
        logic [2:0]   exp_rdy;
        int           m_ptr;
        int           m_cnt;
        int           g;
        bit           ok;
        @(posedge clk); #1;
        rr_rst_n = 1'b0;
        rr_in_valid = 3'b000;
        @(posedge clk); #1;
        rr_rst_n = 1'b1;
        m_ptr = 0;
        m_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            sv[i] = 1'b0;
            sd[i] = '0;
        end
        for (int cyc = 0; cyc < 300; cyc++) begin
            for (int i = 0; i < 3; i++) begin
                if (!sv[i] && ($urandom_range(0, 1) == 1)) begin
                    sv[i] = 1'b1;
                    sd[i] = 11'($urandom);
                end
            end
            rr_in_valid = {sv[2], sv[1], sv[0]};
            rr_in_data = {sd[2], sd[1], sd[0]};
            rr_addr_ready = ($urandom_range(0, 3) != 0);
            rr_data_ready = ($urandom_range(0, 3) != 0);
            ok = (exp_aq.size() == 0 || rr_addr_ready) && (exp_dq.size() == 0 || rr_data_ready);
            g = -1;
            for (int k = 0; k < 3; k++) begin
                if (g < 0 && sv[(m_ptr + k) % 3]) g = (m_ptr + k) % 3;
            end
            exp_rdy = (ok && g >= 0) ? 3'(1 << g) : 3'b000;
            @(negedge clk);
            n_checks++; if (rr_addr_valid !== (exp_aq.size() != 0)) begin n_fail++; $display("FAIL rnd_addr_valid cyc=%0d got=%0b exp=%0b", cyc, rr_addr_valid, (exp_aq.size() != 0)); end
            n_checks++; if (rr_data_valid !== (exp_dq.size() != 0)) begin n_fail++; $display("FAIL rnd_data_valid cyc=%0d got=%0b exp=%0b", cyc, rr_data_valid, (exp_dq.size() != 0)); end
            if (exp_aq.size() != 0) begin
                n_checks++; if (rr_addr_out !== exp_aq[0]) begin n_fail++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", cyc, rr_addr_out, exp_aq[0]); end
            end
            if (exp_dq.size() != 0) begin
                n_checks++; if (rr_data_out !== exp_dq[0]) begin n_fail++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", cyc, rr_data_out, exp_dq[0]); end
            end
            n_checks++; if (rr_in_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_grant cyc=%0d got=%b exp=%b", cyc, rr_in_ready, exp_rdy); end
            n_checks++; if (rr_flit_cnt !== 16'(m_cnt)) begin n_fail++; $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", cyc, rr_flit_cnt, m_cnt); end
            @(posedge clk);
            if (exp_aq.size() != 0 && rr_addr_ready) void'(exp_aq.pop_front());
            if (exp_dq.size() != 0 && rr_data_ready) void'(exp_dq.pop_front());
            if (exp_rdy != 3'b000) begin
                exp_aq.push_back(sd[g][10:4]);
                exp_dq.push_back(sd[g][3:0]);
                m_cnt++;
                m_ptr = (g + 1) % 3;
                sv[g] = 1'b0;
            end
            #1;
        end
        rr_in_valid = 3'b000;
    endtask

    // ------------------------------------------------------------------
    task automatic test_ext_select();
        @(posedge clk); #1;
        ex_in_data = {ef[2], ef[1], ef[0]};
        ex_in_valid = 3'b111;
        ex_addr_ready = 1'b1;
        ex_data_ready = 1'b1;
        ex_ctl_valid = 1'b1;
        ex_ctl_sel = 2'd2;
        @(negedge clk);
        n_checks++; if (ex_ctl_ready !== 1'b1) begin n_fail++; $display("FAIL ext_tok2_ready got=%0b exp=1", ex_ctl_ready); end
        n_checks++; if (ex_in_ready !== 3'b000) begin n_fail++; $display("FAIL ext_idle_nogrant got=%b exp=000", ex_in_ready); end
        @(posedge clk); #1;
        ex_ctl_sel = 2'd3;
        @(negedge clk);
        n_checks++; if (ex_ctl_ready !== 1'b0) begin n_fail++; $display("FAIL ext_wait_ctl got=%0b exp=0", ex_ctl_ready); end
        n_checks++; if (ex_in_ready !== 3'b100) begin n_fail++; $display("FAIL ext_grant2 got=%b exp=100", ex_in_ready); end
        n_checks++; if (ex_dbg_state !== 1'b1) begin n_fail++; $display("FAIL ext_state_wait got=%0b exp=1", ex_dbg_state); end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (ex_addr_valid !== 1'b1 || ex_addr_out !== ef[2][10:4] || ex_data_out !== ef[2][3:0]) begin
            n_fail++; $display("FAIL ext_flit2 got=%0b/%h/%h exp=1/%h/%h", ex_addr_valid, ex_addr_out, ex_data_out, ef[2][10:4], ef[2][3:0]);
        end
        n_checks++; if (ex_flit_cnt !== 4'd1) begin n_fail++; $display("FAIL ext_cnt1 got=%0d exp=1", ex_flit_cnt); end
        n_checks++; if (ex_ctl_ready !== 1'b1 || ex_in_ready !== 3'b000) begin n_fail++; $display("FAIL ext_tok3_take got=%0b/%b exp=1/000", ex_ctl_ready, ex_in_ready); end
        @(posedge clk); #1;
        ex_ctl_sel = 2'd0;
        @(negedge clk);
        n_checks++; if (ex_err_sel !== 1'b1) begin n_fail++; $display("FAIL ext_err_pulse got=%0b exp=1", ex_err_sel); end
        n_checks++; if (ex_addr_valid !== 1'b0 || ex_in_ready !== 3'b000) begin n_fail++; $display("FAIL ext_err_noflit got=%0b/%b exp=0/000", ex_addr_valid, ex_in_ready); end
        @(posedge clk); #1;
        ex_ctl_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (ex_err_sel !== 1'b0) begin n_fail++; $display("FAIL ext_err_once got=%0b exp=0", ex_err_sel); end
        n_checks++; if (ex_in_ready !== 3'b001) begin n_fail++; $display("FAIL ext_grant0 got=%b exp=001", ex_in_ready); end
        @(posedge clk); #1;
        ex_in_valid = 3'b000;
        @(negedge clk);
        n_checks++; if (ex_addr_out !== ef[0][10:4] || ex_data_out !== ef[0][3:0]) begin n_fail++; $display("FAIL ext_flit0 got=%h/%h exp=%h/%h", ex_addr_out, ex_data_out, ef[0][10:4], ef[0][3:0]); end
        n_checks++; if (ex_flit_cnt !== 4'd2) begin n_fail++; $display("FAIL ext_cnt2 got=%0d exp=2", ex_flit_cnt); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_ext_stall();
        @(posedge clk); #1;
        ex_ctl_valid = 1'b1;
        ex_ctl_sel = 2'd1;
        ex_in_valid = 3'b101;
        @(negedge clk);
        n_checks++; if (ex_ctl_ready !== 1'b1) begin n_fail++; $display("FAIL stall_tok got=%0b exp=1", ex_ctl_ready); end
        @(posedge clk); #1;
        ex_ctl_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++; if (ex_in_ready !== 3'b000) begin n_fail++; $display("FAIL stall_others c=%0d got=%b exp=000", c, ex_in_ready); end
            @(posedge clk); #1;
        end
        ex_in_valid = 3'b111;
        @(negedge clk);
        n_checks++; if (ex_in_ready !== 3'b010) begin n_fail++; $display("FAIL stall_grant1 got=%b exp=010", ex_in_ready); end
        @(posedge clk); #1;
        ex_in_valid = 3'b000;
        @(negedge clk);
        n_checks++; if (ex_addr_out !== ef[1][10:4] || ex_flit_cnt !== 4'd3) begin n_fail++; $display("FAIL stall_flit1 got=%h/%0d exp=%h/3", ex_addr_out, ex_flit_cnt, ef[1][10:4]); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_counter_wrap();
        for (int n = 0; n < 14; n++) begin
            @(posedge clk); #1;
            ex_ctl_valid = 1'b1;
            ex_ctl_sel = 2'(n % 3);
            ex_in_valid = 3'b111;
            @(negedge clk);
            n_checks++; if (ex_ctl_ready !== 1'b1) begin n_fail++; $display("FAIL wrap_tok n=%0d got=%0b exp=1", n, ex_ctl_ready); end
            @(posedge clk); #1;
            ex_ctl_valid = 1'b0;
            @(negedge clk);
            n_checks++; if (ex_in_ready !== 3'(1 << (n % 3))) begin n_fail++; $display("FAIL wrap_grant n=%0d got=%b exp=%b", n, ex_in_ready, 3'(1 << (n % 3))); end
        end
        @(posedge clk); #1;
        ex_in_valid = 3'b000;
        @(negedge clk);
        n_checks++; if (ex_flit_cnt !== 4'd1) begin n_fail++; $display("FAIL wrap_cnt got=%0d exp=1", ex_flit_cnt); end
    endtask

    // ------------------------------------------------------------------
    initial begin
        rr_rst_n = 1'b0;
        ex_rst_n = 1'b0;
        rr_in_valid = '0;
        rr_in_data = '0;
        rr_ctl_valid = 1'b0;
        rr_ctl_sel = '0;
        rr_addr_ready = 1'b1;
        rr_data_ready = 1'b1;
        ex_in_valid = '0;
        ex_in_data = '0;
        ex_ctl_valid = 1'b0;
        ex_ctl_sel = '0;
        ex_addr_ready = 1'b1;
        ex_data_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fl[i] = {7'(7'h10 + i), 4'(i + 1)};
            ef[i] = {7'(7'h60 + i), 4'(9 + i)};
        end

        test_reset();
        test_rr_fairness();
        test_field_split();
        test_join_backpressure();
        test_reset_mid_stream();
        test_random_rr();
        test_ext_select();
        test_ext_stall();
        test_counter_wrap();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
